// File: rtl/fft_uart_pkg.sv
// fft_uart_pkg: shared definitions for the FFT-result UART transmit path.
//   Provides the serializer state encoding and helpers that size the
//   per-word byte count and the counter widths from the block parameters.
package fft_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Number of 8-bit UART frames needed for one 2*length-bit word.
  function automatic int calc_bytes(input int length);
    return (2 * length) / 8;
  endfunction

  // Counter width for a counter running 0..n-1; never narrower than 1 bit
  // so a single-byte word still gets a real (constant-zero) byte counter.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_uart_tx_byte.sv
// uart_tx_byte: bit-level 8N1 serializer (start, 8 data bits LSB first,
//   STOP_BITS stop bits, each bit CLKS_PER_BIT cycles).
// Ports: i_clk/i_rst (sync, active-high); i_start begins a frame on the same
//   edge (line drops to 0 immediately); i_byte is read live for each data
//   bit; o_serial registered line; o_done is high during the final cycle of
//   the last stop bit, so a new i_start on that edge gives a gapless frame.
module uart_tx_byte
  import fft_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_serial,
  output logic       o_done
);

  localparam int BW = cnt_width(CLKS_PER_BIT);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          stop_q;
  logic          serial_q;
  logic          bit_end;
  logic          last_stop;

  assign bit_end   = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));
  // Decoded from registers only; lets the parent chain the next frame.
  assign o_done    = (state_q == ST_STOP) && bit_end && last_stop;
  assign o_serial  = serial_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= 1'b1;
    end else if (i_start) begin
      // Start bit goes on the line at the accepting edge itself.
      state_q  <= ST_START;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          serial_q <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            baud_q   <= '0;
            bit_q    <= '0;
            serial_q <= i_byte[0];
            state_q  <= ST_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              stop_q   <= 1'b0;
              serial_q <= 1'b1;
              state_q  <= ST_STOP;
            end else begin
              bit_q    <= bit_q + 3'd1;
              serial_q <= i_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (last_stop) begin
              state_q  <= ST_IDLE;
              serial_q <= 1'b1;
            end else begin
              stop_q <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          serial_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fft_uart_tx.sv
// fft_uart_tx: sends one 2*LENGTH-bit word per valid/ready handshake as
//   BYTES back-to-back 8N1 frames, most-significant byte first.
// Ports: i_clk/i_rst (sync, active-high); i_tx_valid/i_fft_data word input,
//   o_tx_ready high when idle (falls on the accepting edge); o_tx_serial line;
//   o_tx_busy while a word is on the line; o_word_done one-cycle end pulse.
module fft_uart_tx
  import fft_uart_pkg::*;
#(
  parameter int LENGTH       = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tx_valid,
  input  logic [2*LENGTH-1:0]   i_fft_data,
  output logic                  o_tx_ready,
  output logic                  o_tx_serial,
  output logic                  o_tx_busy,
  output logic                  o_word_done
);

  localparam int W     = 2 * LENGTH;
  localparam int BYTES = calc_bytes(LENGTH);
  localparam int BCW   = cnt_width(BYTES);

  logic [W-1:0]   shift_q, shift_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic           word_done_q, word_done_d;

  logic accept;
  logic byte_done;
  logic last_byte;
  logic byte_start;

  // Valid while not ready is simply dropped: nothing is queued.
  assign accept     = i_tx_valid && ready_q;
  assign last_byte  = (byte_cnt_q == BCW'(BYTES - 1));
  // Next byte starts on the same edge the previous stop bit ends.
  assign byte_start = accept || (byte_done && !last_byte);

  always_comb begin
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    ready_d     = ready_q;
    busy_d      = busy_q;
    word_done_d = 1'b0;
    if (accept) begin
      shift_d    = i_fft_data;
      byte_cnt_d = '0;
      ready_d    = 1'b0;
      busy_d     = 1'b1;
    end else if (byte_done) begin
      if (last_byte) begin
        ready_d     = 1'b1;
        busy_d      = 1'b0;
        word_done_d = 1'b1;
      end else begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
        shift_d    = shift_q << 8;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  // The byte being sent is always the top 8 bits of the shift register.
  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_byte (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (byte_start),
    .i_byte   (shift_q[W-1 -: 8]),
    .o_serial (o_tx_serial),
    .o_done   (byte_done)
  );

  assign o_tx_ready  = ready_q;
  assign o_tx_busy   = busy_q;
  assign o_word_done = word_done_q;

endmodule

// File: tb/tb_fft_uart_tx.sv
// Directed bench for fft_uart_tx: two instances (1 and 2 stop bits) at
// 4 clocks per bit; the line is decoded cycle by cycle and compared with
// hand-computed words and frame timings.
module tb_fft_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst2, vld, vld2;
  logic [63:0] dat, dat2;
  logic        rdy, ser, busy, done;
  logic        rdy2, ser2, busy2, done2;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] got;
  int          bad, dn, errs;

  fft_uart_tx #(.LENGTH(32), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_valid(vld), .i_fft_data(dat),
    .o_tx_ready(rdy), .o_tx_serial(ser), .o_tx_busy(busy), .o_word_done(done)
  );

  fft_uart_tx #(.LENGTH(32), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_tx_valid(vld2), .i_fft_data(dat2),
    .o_tx_ready(rdy2), .o_tx_serial(ser2), .o_tx_busy(busy2), .o_word_done(done2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called on a negedge with ready high; returns on the negedge just after
  // the accepting edge, i.e. the first cycle of the start bit.
  task automatic start_word(input bit sel, input logic [63:0] w);
    if (sel) begin dat2 = w; vld2 = 1'b1; end
    else     begin dat  = w; vld  = 1'b1; end
    @(negedge clk);
    vld  = 1'b0;
    vld2 = 1'b0;
  endtask

  // Samples the line once per cycle for nbytes frames of 4-cycle bits.
  // bad counts unstable bits and wrong start/stop levels; dones counts
  // word_done pulses seen while the word is still on the line.
  task automatic rx_word(input bit sel, input int nbytes, input int sbits,
                         output logic [63:0] w, output int nbad, output int dones);
    logic       b0, s;
    logic [7:0] byt;
    w = '0; nbad = 0; dones = 0;
    for (int by = 0; by < nbytes; by++) begin
      byt = '0;
      for (int bt = 0; bt < 9 + sbits; bt++) begin
        b0 = sel ? ser2 : ser;
        for (int j = 0; j < 4; j++) begin
          s = sel ? ser2 : ser;
          if (s !== b0) nbad++;
          if ((sel ? done2 : done) === 1'b1) dones++;
          @(negedge clk);
        end
        if (bt == 0) begin
          if (b0 !== 1'b0) nbad++;
        end else if (bt <= 8) begin
          byt[bt-1] = b0;
        end else begin
          if (b0 !== 1'b1) nbad++;
        end
      end
      w = {w[55:0], byt};
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; vld = 1'b0; vld2 = 1'b0; dat = '0; dat2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  64'(rdy),  64'd1);
    chk("rst_serial", 64'(ser),  64'd1);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst2_ready", 64'(rdy2), 64'd1);
    rst = 1'b0; rst2 = 1'b0;

    // Idle for 100 cycles with no valid.
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (ser !== 1'b1 || rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
    end
    chk("idle_100", 64'(errs), 64'd0);

    // Single word: 8 frames of 40 cycles, done exactly 320 cycles after accept.
    start_word(1'b0, 64'h0123456789ABCDEF);
    chk("w1_busy_on", 64'(busy), 64'd1);
    chk("w1_ready_off", 64'(rdy), 64'd0);
    rx_word(1'b0, 8, 1, got, bad, dn);
    chk("w1_bytes",   got, 64'h0123456789ABCDEF);
    chk("w1_framing", 64'(bad), 64'd0);
    chk("w1_early_done", 64'(dn), 64'd0);
    chk("w1_done",  64'(done), 64'd1);
    chk("w1_ready", 64'(rdy),  64'd1);
    chk("w1_busy",  64'(busy), 64'd0);
    @(negedge clk);
    chk("w1_done_one_cycle", 64'(done), 64'd0);

    // Valid with all-ones at cycle 50 of a word must be ignored.
    start_word(1'b0, 64'h1122334455667788);
    fork
      rx_word(1'b0, 8, 1, got, bad, dn);
      begin
        repeat (50) @(negedge clk);
        dat = 64'hFFFF_FFFF_FFFF_FFFF; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
      end
    join
    chk("busy_bytes",   got, 64'h1122334455667788);
    chk("busy_framing", 64'(bad), 64'd0);
    chk("busy_done",    64'(done), 64'd1);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || ser !== 1'b1) errs++;
    end
    chk("busy_no_second_word", 64'(errs), 64'd0);

    // Back-to-back: second valid on the first cycle ready is high.
    start_word(1'b0, 64'h0123456789ABCDEF);
    rx_word(1'b0, 8, 1, got, bad, dn);
    chk("b2b_w1_bytes", got, 64'h0123456789ABCDEF);
    chk("b2b_w1_done",  64'(done), 64'd1);
    chk("b2b_gap_high", 64'(ser), 64'd1);
    start_word(1'b0, 64'hA5A5A5A5_5A5A5A5A);
    rx_word(1'b0, 8, 1, got, bad, dn);
    chk("b2b_w2_bytes",   got, 64'hA5A5A5A5_5A5A5A5A);
    chk("b2b_w2_framing", 64'(bad), 64'd0);
    chk("b2b_w2_done",    64'(done), 64'd1);

    // Two stop bits: 44-cycle frames, 352 cycles per word.
    start_word(1'b1, 64'h00000000_000000FF);
    rx_word(1'b1, 8, 2, got, bad, dn);
    chk("sb2_bytes",   got, 64'h00000000_000000FF);
    chk("sb2_framing", 64'(bad), 64'd0);
    chk("sb2_early_done", 64'(dn), 64'd0);
    chk("sb2_done",  64'(done2), 64'd1);
    chk("sb2_ready", 64'(rdy2),  64'd1);

    // Reset in the middle of byte 3's data bits (cycle 130 of 320).
    @(negedge clk);
    start_word(1'b0, 64'hDEADBEEF_CAFEF00D);
    repeat (130) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_serial", 64'(ser),  64'd1);
    chk("mid_rst_ready",  64'(rdy),  64'd1);
    chk("mid_rst_busy",   64'(busy), 64'd0);
    chk("mid_rst_done",   64'(done), 64'd0);
    rst = 1'b0;
    start_word(1'b0, 64'h1);
    rx_word(1'b0, 8, 1, got, bad, dn);
    chk("post_rst_bytes",   got, 64'h1);
    chk("post_rst_framing", 64'(bad), 64'd0);
    chk("post_rst_done",    64'(done), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
